// File: rtl/trm_fetch_pkg.sv
// Shared defaults and types for the TRM fetch stage.
// Package: no logic, no latency, no flow control.
package trm_fetch_pkg;

  localparam int unsigned TRM_DW       = 36;
  localparam int unsigned TRM_AW       = 10;
  localparam int unsigned TRM_RESET_PC = 0;

  typedef logic [TRM_AW-1:0] pc_t;
  typedef logic [TRM_DW-1:0] instr_t;

  // The only fetch state is whether pmout carries a tagged word.
  typedef enum logic {
    F2_EMPTY = 1'b0,
    F2_FULL  = 1'b1
  } f2_state_e;

endpackage

// File: rtl/trm_fetch_perf.sv
// Fetch performance counters: completed handshakes and decode-stall cycles.
// Latency: counts visible one cycle after the event; no backpressure, wraps at 2^32.
module trm_fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (ins_valid && ins_ready) fetched_d = fetched_q + 32'd1;
    if (ins_valid && !ins_ready) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;

endmodule

// File: rtl/trm_fetch.sv
// TRM fetch stage: PC, combinational IM address, tagged instruction to decode (TRM_FETCH_PERF_EN adds counters).
// Latency: one cycle from pmadr to ins_valid; redirects land the following cycle.
// Backpressure: ins_ready low re-reads the held address so ins/ins_pc stay stable.
module trm_fetch
  import trm_fetch_pkg::*;
#(
  parameter int unsigned DW       = TRM_DW,
  parameter int unsigned AW       = TRM_AW,
  parameter int unsigned RESET_PC = TRM_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  output logic [31:0]   pmadr,
  input  logic [DW-1:0] pmout,
  output logic [DW-1:0] ins,
  output logic [AW-1:0] ins_pc,
  output logic          ins_valid,
  input  logic          ins_ready,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target,
`ifdef TRM_FETCH_PERF_EN
  input  logic          halt,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall
`else
  input  logic          halt
`endif
);

  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);
  localparam logic [AW-1:0] PC_ONE = AW'(1);

  f2_state_e     state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] f2_pc_q, f2_pc_d;
  logic [AW-1:0] fetch_adr;
  logic          f2_valid;
  logic          advance;

  assign f2_valid = (state_q == F2_FULL);
  assign advance  = ~halt & (~f2_valid | ins_ready);

  // IM registers whatever we present, so a stall must re-present f2_pc.
  always_comb begin
    fetch_adr = f2_pc_q;
    if (!rst)          fetch_adr = RST_PC;
    else if (br_valid) fetch_adr = br_target;
    else if (advance)  fetch_adr = pc_q;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    f2_pc_d = f2_pc_q;
    if (br_valid) begin
      state_d = F2_FULL;
      f2_pc_d = br_target;
      pc_d    = br_target + PC_ONE;
    end else if (advance) begin
      state_d = F2_FULL;
      f2_pc_d = pc_q;
      pc_d    = pc_q + PC_ONE;
    end else if (halt && f2_valid && ins_ready) begin
      state_d = F2_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= F2_EMPTY;
      pc_q    <= RST_PC;
      f2_pc_q <= RST_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      f2_pc_q <= f2_pc_d;
    end
  end

  assign pmadr  = {{(32-AW){1'b0}}, fetch_adr};
  assign ins    = pmout;
  assign ins_pc = f2_pc_q;
  // A flushed word is never offered, and nothing handshakes during reset.
  assign ins_valid = f2_valid & ~br_valid & rst;

`ifdef TRM_FETCH_PERF_EN
  trm_fetch_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_trm_fetch.sv
// Bench for trm_fetch paired with a behavioural IM holding word n = n.
module tb_trm_fetch;

  localparam int DW = 36;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pmadr;
  logic [DW-1:0] pmout;
  logic [DW-1:0] ins;
  logic [AW-1:0] ins_pc;
  logic          ins_valid;
  logic          ins_ready;
  logic          br_valid;
  logic [AW-1:0] br_target;
  logic          halt;
`ifdef TRM_FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_e;
  logic [DW-1:0] mem [1 << AW];

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
  end

  always @(posedge clk) pmout <= mem[pmadr[AW-1:0]];

  trm_fetch #(.DW(DW), .AW(AW), .RESET_PC(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .pmadr        (pmadr),
    .pmout        (pmout),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .br_valid     (br_valid),
    .br_target    (br_target),
`ifdef TRM_FETCH_PERF_EN
    .halt         (halt),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`else
    .halt         (halt)
`endif
  );

  // Every completed handshake must match the next expected instruction.
  always @(negedge clk) begin
    if (ins_valid === 1'b1 && ins_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL accept_unexpected: ins_pc=%h ins=%h, none expected", ins_pc, ins);
      end else begin
        mon_e = exp_q.pop_front();
        if (ins_pc !== mon_e || ins !== DW'(mon_e)) begin
          miscompares++;
          $display("FAIL accept_order: ins_pc=%h ins=%h, expected pc=%h ins=%h", ins_pc, ins, mon_e, DW'(mon_e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ins_ready = 1'b0; halt = 1'b0; br_valid = 1'b0; br_target = '0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (ins_valid !== 1'b0 || pmadr !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_hold: ins_valid=%b pmadr=%h, expected 0/0", ins_valid, pmadr);
      end
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0 || pmadr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_first_cycle: ins_valid=%b pmadr=%h, expected 0/0", ins_valid, pmadr);
    end
    tick();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 5; i++) begin
      ins_ready = 1'b1;
      exp_q.push_back(AW'(i));
      @(negedge clk);
      vectors++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(i)) begin
        miscompares++;
        $display("FAIL seq_stream: valid=%b ins_pc=%h, expected 1/%h", ins_valid, ins_pc, AW'(i));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    br_valid = 1'b1; br_target = AW'(2); ins_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_setup_flush: ins_valid=%b, expected 0", ins_valid);
    end
    tick();
    br_valid = 1'b0; ins_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(2) || ins !== DW'(2) || pmadr !== 32'd2) begin
        miscompares++;
        $display("FAIL stall_stable: valid=%b pc=%h ins=%h pmadr=%h, expected 1/2/2/2", ins_valid, ins_pc, ins, pmadr);
      end
      tick();
    end
    ins_ready = 1'b1;
    for (int i = 2; i < 5; i++) begin
      exp_q.push_back(AW'(i));
      @(negedge clk);
      vectors++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(i)) begin
        miscompares++;
        $display("FAIL stall_release: valid=%b ins_pc=%h, expected 1/%h", ins_valid, ins_pc, AW'(i));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    ins_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b1 || ins_pc !== AW'(5)) begin
      miscompares++;
      $display("FAIL redir_stalled: valid=%b ins_pc=%h, expected 1/005", ins_valid, ins_pc);
    end
    tick();
    br_valid = 1'b1; br_target = AW'('h100);
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0 || pmadr !== 32'h100) begin
      miscompares++;
      $display("FAIL redir_flush: valid=%b pmadr=%h, expected 0/100", ins_valid, pmadr);
    end
    tick();
    br_valid = 1'b0; ins_ready = 1'b1;
    for (int i = 'h100; i < 'h102; i++) begin
      exp_q.push_back(AW'(i));
      @(negedge clk);
      vectors++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(i)) begin
        miscompares++;
        $display("FAIL redir_target: valid=%b ins_pc=%h, expected 1/%h", ins_valid, ins_pc, AW'(i));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] p;
    br_valid = 1'b1; br_target = AW'('h3FD); ins_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_br_wins: ins_valid=%b with ready high, expected 0", ins_valid);
    end
    tick();
    br_valid = 1'b0;
    p = AW'('h3FD);
    repeat (5) begin
      exp_q.push_back(p);
      @(negedge clk);
      vectors++;
      if (ins_valid !== 1'b1 || ins_pc !== p || pmadr !== {22'd0, p + AW'(1)}) begin
        miscompares++;
        $display("FAIL wrap_seq: valid=%b ins_pc=%h pmadr=%h, expected 1/%h/%h", ins_valid, ins_pc, pmadr, p, {22'd0, p + AW'(1)});
      end
      p = p + AW'(1);
      tick();
    end
  endtask

  task automatic test_halt();
    halt = 1'b1; ins_ready = 1'b1;
    exp_q.push_back(AW'(2));
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b1 || ins_pc !== AW'(2)) begin
      miscompares++;
      $display("FAIL halt_last_word: valid=%b ins_pc=%h, expected 1/002", ins_valid, ins_pc);
    end
    tick();
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (ins_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_idle: ins_valid=%b, expected 0", ins_valid);
      end
      tick();
    end
    halt = 1'b0;
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0 || pmadr !== 32'd3) begin
      miscompares++;
      $display("FAIL halt_resume_fetch: valid=%b pmadr=%h, expected 0/3", ins_valid, pmadr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 3; i < 7; i++) begin
      exp_q.push_back(AW'(i));
      @(negedge clk);
      vectors++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(i)) begin
        miscompares++;
        $display("FAIL resume_seq: valid=%b ins_pc=%h, expected 1/%h", ins_valid, ins_pc, AW'(i));
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0 || ins_pc !== AW'(7) || pmadr !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_cycle: valid=%b ins_pc=%h pmadr=%h, expected 0/007/0", ins_valid, ins_pc, pmadr);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: ins_valid=%b, expected 0", ins_valid);
    end
`ifdef TRM_FETCH_PERF_EN
    vectors++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_cleared: fetched=%0d stall=%0d, expected 0/0", perf_fetched, perf_stall);
    end
`endif
    tick();
    exp_q.push_back(AW'(0));
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b1 || ins_pc !== AW'(0)) begin
      miscompares++;
      $display("FAIL midreset_restart: valid=%b ins_pc=%h, expected 1/000", ins_valid, ins_pc);
    end
    tick();
    ins_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected instructions never accepted, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
